dot_seq: RTL and testbench

DOT_SEQ -- requirements
Module: dot_seq

---
 rtl/dot_seq_pkg.sv | 16 +
 rtl/dot_seq.sv | 134 +++++++++++++
 tb/tb_dot_seq.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_seq_pkg.sv
// Shared definitions for the dot-product sequencer: FSM state encoding and
// default widths for operands, accumulator result and vector length.
package dot_seq_pkg;

  localparam int DOT_DATA_W = 8;
  localparam int DOT_ACC_W  = 26;
  localparam int DOT_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dot_seq.sv
// Dot-product sequencer. Streams len operand pairs into a downstream MAC,
// waits one cycle for the MAC to absorb the final pair, then captures the
// MAC accumulator as the result and pulses done. The block itself does no
// arithmetic on the operands; the MAC lives beside it in the datapath top.
module dot_seq
  import dot_seq_pkg::*;
#(
  parameter int DATA_W = DOT_DATA_W,
  parameter int ACC_W  = DOT_ACC_W,
  parameter int LEN_W  = DOT_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              in_rdy,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_clr_n,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic [ACC_W-1:0]  result,
  output logic              done,
  output logic              busy
);

  state_t            state_q;
  state_t            state_d;
  logic [LEN_W-1:0]  remaining_q;
  logic              xfer;
  logic              capture;
  logic [DATA_W-1:0] mac_a_p0;
  logic [DATA_W-1:0] mac_b_p0;
  logic [ACC_W-1:0]  result_q;
  logic              done_q;

  // State register; reset lands in IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake and capture decode. abort wins over everything
  // outside IDLE; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    xfer    = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          in_rdy = 1'b1;
          if (in_vld) begin
            xfer = 1'b1;
            if (remaining_q == LEN_W'(1)) begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        state_d = abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        capture = !abort;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pair counter: loaded with len on start, decremented on every transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      remaining_q <= len;
    end else if (xfer) begin
      remaining_q <= remaining_q - LEN_W'(1);
    end
  end

  // Stage p0: operand register to the MAC; zero whenever no pair moves so
  // the MAC adds nothing on idle or aborted cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_a_p0 <= '0;
      mac_b_p0 <= '0;
    end else if (xfer) begin
      mac_a_p0 <= in_a;
      mac_b_p0 <= in_b;
    end else begin
      mac_a_p0 <= '0;
      mac_b_p0 <= '0;
    end
  end

  // Result capture and one-cycle done pulse, taken from the MAC in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= capture;
      if (capture) begin
        result_q <= mac_acc;
      end
    end
  end

  assign mac_a     = mac_a_p0;
  assign mac_b     = mac_b_p0;
  assign result    = result_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign mac_clr_n = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dot_seq.sv
// Self-checking bench for dot_seq. A stand-in MAC closes the loop on
// mac_a/mac_b/mac_clr_n -> mac_acc; expected results are sums of products
// of the pairs handed in, and done timing is counted from the last transfer.
module tb_dot_seq;
  import dot_seq_pkg::*;

  localparam int DATA_W = DOT_DATA_W;
  localparam int ACC_W  = DOT_ACC_W;
  localparam int LEN_W  = DOT_LEN_W;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b1;
  logic              start  = 1'b0;
  logic [LEN_W-1:0]  len    = '0;
  logic              abort  = 1'b0;
  logic              in_vld = 1'b0;
  logic [DATA_W-1:0] in_a   = '0;
  logic [DATA_W-1:0] in_b   = '0;
  logic              in_rdy;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic              mac_clr_n;
  logic [ACC_W-1:0]  mac_acc;
  logic [ACC_W-1:0]  result;
  logic              done;
  logic              busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int rdy_cnt  = 0;

  logic [DATA_W-1:0] va [256];
  logic [DATA_W-1:0] vb [256];
  int                vgap [256];

  typedef struct {
    int               n;
    int               gap;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic [ACC_W-1:0] exp;
    string            nm;
  } vec_t;

  vec_t tab [5];

  dot_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .in_vld    (in_vld),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_rdy    (in_rdy),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_clr_n (mac_clr_n),
    .mac_acc   (mac_acc),
    .result    (result),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Downstream MAC stand-in: clears while mac_clr_n is low, else accumulates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mac_acc <= '0;
    else if (!mac_clr_n) mac_acc <= '0;
    else mac_acc <= mac_acc + ACC_W'(mac_a) * ACC_W'(mac_b);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic logic [ACC_W-1:0] ref_sum(input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'(va[i]) * longint'(vb[i]);
    return ACC_W'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done) done_cnt++;
    if (in_rdy) rdy_cnt++;
  endtask

  // One complete run of n pairs from va/vb with vgap idle cycles before each.
  task automatic run_task(input int n, input logic [ACC_W-1:0] exp, input string nm);
    int last_x;
    int exp_cyc;
    int d0;
    int r0;
    bit seen;
    d0 = done_cnt;
    r0 = rdy_cnt;
    len   = LEN_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    len   = '0;
    last_x = cyc;
    chk({nm, "_busy"}, busy, 1);
    chk({nm, "_clr_n"}, mac_clr_n, 1);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < vgap[i]; g++) begin
        in_vld = 1'b0;
        #1;
        chk({nm, "_gap_rdy"}, in_rdy, 1);
        tick();
        chk({nm, "_gap_mac_a"}, mac_a, 0);
        chk({nm, "_gap_mac_b"}, mac_b, 0);
      end
      in_vld = 1'b1;
      in_a   = va[i];
      in_b   = vb[i];
      #1;
      chk({nm, "_rdy"}, in_rdy, 1);
      tick();
      last_x = cyc;
      chk({nm, "_mac_a"}, mac_a, va[i]);
      chk({nm, "_mac_b"}, mac_b, vb[i]);
    end
    in_vld = 1'b0;
    in_a   = '0;
    in_b   = '0;
    exp_cyc = last_x + ((n == 0) ? 1 : 2);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, seen, 1);
    chk({nm, "_done_cycle"}, cyc, exp_cyc);
    chk({nm, "_result"}, result, exp);
    tick();
    chk({nm, "_done_low"}, done, 0);
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_idle_clr_n"}, mac_clr_n, 0);
    chk({nm, "_done_count"}, done_cnt - d0, 1);
    if (n == 0) chk({nm, "_rdy_never"}, rdy_cnt - r0, 0);
  endtask

  initial begin
    int d0;
    int n;

    tab[0] = '{0, 0, 32'h00000000, 32'h00000000, 26'd0,      "len0"};
    tab[1] = '{2, 1, 32'h0000030A, 32'h00000414, 26'd212,    "two_gap1"};
    tab[2] = '{4, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 26'd260100, "max_ops"};
    tab[3] = '{3, 0, 32'h00010402, 32'h00010503, 26'd27,     "b2b"};
    tab[4] = '{3, 2, 32'h00010402, 32'h00010503, 26'd27,     "gapped"};

    // reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mac_a", mac_a, 0);
    chk("rst_mac_b", mac_b, 0);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_clr_n", mac_clr_n, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // table-driven runs
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < tab[t].n; i++) begin
        va[i]   = tab[t].a[i];
        vb[i]   = tab[t].b[i];
        vgap[i] = (i == 0) ? 0 : tab[t].gap;
      end
      run_task(tab[t].n, tab[t].exp, tab[t].nm);
    end

    // abort in ACC after two of four transfers
    d0 = done_cnt;
    len = LEN_W'(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_vld = 1'b1;
      in_a = 8'd2 + DATA_W'(i);
      in_b = 8'd3;
      tick();
    end
    in_a = 8'd50;
    in_b = 8'd50;
    abort = 1'b1;
    #1;
    chk("abort_acc_rdy", in_rdy, 0);
    tick();
    abort = 1'b0;
    in_vld = 1'b0;
    chk("abort_acc_idle", busy, 0);
    chk("abort_acc_mac_a", mac_a, 0);
    chk("abort_acc_mac_b", mac_b, 0);
    chk("abort_acc_clr_n", mac_clr_n, 0);
    repeat (4) tick();
    chk("abort_acc_no_done", done_cnt - d0, 0);
    chk("abort_acc_result", result, 27);
    va[0] = 8'd7; vb[0] = 8'd9; vgap[0] = 0;
    run_task(1, 26'd63, "after_abort");

    // abort in DRAIN
    d0 = done_cnt;
    len = LEN_W'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    in_vld = 1'b1; in_a = 8'd3; in_b = 8'd3;
    tick();
    in_vld = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_drain_idle", busy, 0);
    repeat (3) tick();
    chk("abort_drain_no_done", done_cnt - d0, 0);
    chk("abort_drain_result", result, 63);

    // abort in DONE
    d0 = done_cnt;
    len = LEN_W'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    in_vld = 1'b1; in_a = 8'd5; in_b = 8'd5;
    tick();
    in_vld = 1'b0;
    tick();
    chk("abort_done_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done_idle", busy, 0);
    chk("abort_done_pulse", done, 0);
    repeat (3) tick();
    chk("abort_done_no_done", done_cnt - d0, 0);
    chk("abort_done_result", result, 63);

    // start while busy is ignored, then reset mid-ACC
    d0 = done_cnt;
    len = LEN_W'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    len = '0;
    in_vld = 1'b1; in_a = 8'd1; in_b = 8'd2;
    tick();
    in_vld = 1'b0;
    len = LEN_W'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    len = '0;
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    #1;
    chk("busy_start_still_acc", busy, 1);
    chk("busy_start_rdy", in_rdy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rdy", in_rdy, 0);
    chk("midrst_mac_a", mac_a, 0);
    chk("midrst_clr_n", mac_clr_n, 0);
    chk("midrst_result", result, 0);
    chk("midrst_done", done, 0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_idle", busy, 0);

    // full-length run of unit pairs
    for (int i = 0; i < 255; i++) begin
      va[i] = 8'd1; vb[i] = 8'd1; vgap[i] = 0;
    end
    run_task(255, 26'd255, "len255");

    // randomized runs against the sum-of-products model
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 24));
      for (int i = 0; i < n; i++) begin
        va[i]   = DATA_W'($urandom_range(0, 255));
        vb[i]   = DATA_W'($urandom_range(0, 255));
        vgap[i] = int'($urandom_range(0, 2));
      end
      run_task(n, ref_sum(n), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
